// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - RV32I decode stage: register file, hazard detection, ID/EX pipeline register
// Optional feature macro: DECODE_WB_BYPASS_EN (same-cycle writeback forwarding into register reads)
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_if_valid,
  input  logic [31:0]     i_if_inst,
  input  logic [XLEN-1:0] i_if_pc,
  output logic            o_if_ready,
  input  logic            i_flush,
  input  logic            i_wb_wen,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_rs1_data,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [AW-1:0]   o_ex_rd_addr,
  output logic            o_ex_rd_wen,
  output logic            o_ex_mem_ren,
  output logic            o_ex_mem_wen,
  output logic [6:0]      o_ex_opcode,
  output logic [2:0]      o_ex_funct3,
  output logic            o_ex_funct7b5
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Register file state
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rf_d [NUM_REGS];

  // ID/EX pipeline register state
  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0]   ex_rd_addr_q, ex_rd_addr_d;
  logic            ex_rd_wen_q, ex_rd_wen_d;
  logic            ex_mem_ren_q, ex_mem_ren_d;
  logic            ex_mem_wen_q, ex_mem_wen_d;
  logic [6:0]      ex_opcode_q, ex_opcode_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;

  // Instruction fields, truncated to the register address width
  logic [4:0]      rs1_field, rs2_field, rd_field;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
  logic [6:0]      opcode;

  assign opcode    = i_if_inst[6:0];
  assign rd_field  = i_if_inst[11:7];
  assign rs1_field = i_if_inst[19:15];
  assign rs2_field = i_if_inst[24:20];
  assign rd_addr   = rd_field[AW-1:0];
  assign rs1_addr  = rs1_field[AW-1:0];
  assign rs2_addr  = rs2_field[AW-1:0];

  // A writeback to x0 is architecturally a no-op
  logic wb_hit;
  assign wb_hit = i_wb_wen && (i_wb_addr != '0);

  logic [XLEN-1:0] rs1_val, rs2_val;

  // Combinational operand reads; x0 and out-of-range addresses read zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((rs1_addr != '0) && (int'(rs1_addr) < NUM_REGS)) rs1_val = rf_q[rs1_addr];
    if ((rs2_addr != '0) && (int'(rs2_addr) < NUM_REGS)) rs2_val = rf_q[rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_hit && (i_wb_addr == rs1_addr)) rs1_val = i_wb_data;
    if (wb_hit && (i_wb_addr == rs2_addr)) rs2_val = i_wb_data;
`endif
  end

  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_wen, dec_mem_ren, dec_mem_wen;

  // Opcode decode: immediate format and control bits; unknown opcodes become NOPs
  always_comb begin
    imm32       = '0;
    dec_rd_wen  = 1'b0;
    dec_mem_ren = 1'b0;
    dec_mem_wen = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        imm32      = {i_if_inst[31:12], 12'b0};
        dec_rd_wen = 1'b1;
      end
      OP_JAL: begin
        imm32      = {{12{i_if_inst[31]}}, i_if_inst[19:12], i_if_inst[20], i_if_inst[30:21], 1'b0};
        dec_rd_wen = 1'b1;
      end
      OP_JALR, OP_IMM: begin
        imm32      = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        dec_rd_wen = 1'b1;
      end
      OP_LOAD: begin
        imm32       = {{20{i_if_inst[31]}}, i_if_inst[31:20]};
        dec_rd_wen  = 1'b1;
        dec_mem_ren = 1'b1;
      end
      OP_STORE: begin
        imm32       = {{20{i_if_inst[31]}}, i_if_inst[31:25], i_if_inst[11:7]};
        dec_mem_wen = 1'b1;
      end
      OP_BRANCH: begin
        imm32 = {{20{i_if_inst[31]}}, i_if_inst[7], i_if_inst[30:25], i_if_inst[11:8], 1'b0};
      end
      OP_REG: begin
        dec_rd_wen = 1'b1;
      end
      default: begin
      end
    endcase
    if (rd_addr == '0) dec_rd_wen = 1'b0;
  end

  assign dec_imm = XLEN'($signed(imm32));

  // Stall and hazard conditions
  logic adv, load_use, wb_hazard, hazard;

  assign adv      = !ex_valid_q || i_ex_ready;
  assign load_use = ex_valid_q && ex_mem_ren_q && (ex_rd_addr_q != '0) &&
                    ((ex_rd_addr_q == rs1_addr) || (ex_rd_addr_q == rs2_addr));
`ifdef DECODE_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  assign wb_hazard = wb_hit && ((i_wb_addr == rs1_addr) || (i_wb_addr == rs2_addr));
`endif
  assign hazard     = load_use || wb_hazard;
  assign o_if_ready = i_flush || (adv && !hazard);

  // Register file next state: writeback lands regardless of stall or flush
  always_comb begin
    rf_d = rf_q;
    if (wb_hit && (int'(i_wb_addr) < NUM_REGS)) rf_d[i_wb_addr] = i_wb_data;
  end

  // ID/EX next state: flush, stall, bubble, load, drain in priority order
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_rd_wen_d   = ex_rd_wen_q;
    ex_mem_ren_d  = ex_mem_ren_q;
    ex_mem_wen_d  = ex_mem_wen_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    if (i_flush) begin
      ex_valid_d = 1'b0;
    end else if (!adv) begin
      ex_valid_d = ex_valid_q;
    end else if (hazard) begin
      ex_valid_d = 1'b0;
    end else if (i_if_valid) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = i_if_pc;
      ex_rs1_d      = rs1_val;
      ex_rs2_d      = rs2_val;
      ex_imm_d      = dec_imm;
      ex_rd_addr_d  = rd_addr;
      ex_rd_wen_d   = dec_rd_wen;
      ex_mem_ren_d  = dec_mem_ren;
      ex_mem_wen_d  = dec_mem_wen;
      ex_opcode_d   = opcode;
      ex_funct3_d   = i_if_inst[14:12];
      ex_funct7b5_d = i_if_inst[30];
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  // Register file storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // ID/EX pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_addr_q  <= '0;
      ex_rd_wen_q   <= 1'b0;
      ex_mem_ren_q  <= 1'b0;
      ex_mem_wen_q  <= 1'b0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_rd_wen_q   <= ex_rd_wen_d;
      ex_mem_ren_q  <= ex_mem_ren_d;
      ex_mem_wen_q  <= ex_mem_wen_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
    end
  end

  assign o_ex_valid    = ex_valid_q;
  assign o_ex_pc       = ex_pc_q;
  assign o_ex_rs1_data = ex_rs1_q;
  assign o_ex_rs2_data = ex_rs2_q;
  assign o_ex_imm      = ex_imm_q;
  assign o_ex_rd_addr  = ex_rd_addr_q;
  assign o_ex_rd_wen   = ex_rd_wen_q;
  assign o_ex_mem_ren  = ex_mem_ren_q;
  assign o_ex_mem_wen  = ex_mem_wen_q;
  assign o_ex_opcode   = ex_opcode_q;
  assign o_ex_funct3   = ex_funct3_q;
  assign o_ex_funct7b5 = ex_funct7b5_q;

endmodule
